// File: rtl/time_set_if.sv
// time_set_if: bus between the keypad/clock side and the time-setting
// controller.
//   Key_flag, Key_Value  one-cycle key event and its key code
//   Cur_Time_i           running BCD time {Ht,Ho,Mt,Mo,St,So}
//   Set_Time_o, Set_Load_o           time load towards the clock counter
//   Alarm_Time_o, Alarm_En_o         alarm registers
//   Edit_Active_o, Edit_Target_o, Edit_Idx_o, Edit_Buf_o  edit state for display
//   Err_o                one-cycle rejected-key pulse
// master = keypad/clock/display side, slave = controller.
interface time_set_if;
  logic        Key_flag;
  logic [3:0]  Key_Value;
  logic [23:0] Cur_Time_i;
  logic [23:0] Set_Time_o;
  logic        Set_Load_o;
  logic [15:0] Alarm_Time_o;
  logic        Alarm_En_o;
  logic        Edit_Active_o;
  logic        Edit_Target_o;
  logic [2:0]  Edit_Idx_o;
  logic [23:0] Edit_Buf_o;
  logic        Err_o;

  modport master (
    output Key_flag, Key_Value, Cur_Time_i,
    input  Set_Time_o, Set_Load_o, Alarm_Time_o, Alarm_En_o,
           Edit_Active_o, Edit_Target_o, Edit_Idx_o, Edit_Buf_o, Err_o
  );

  modport slave (
    input  Key_flag, Key_Value, Cur_Time_i,
    output Set_Time_o, Set_Load_o, Alarm_Time_o, Alarm_En_o,
           Edit_Active_o, Edit_Target_o, Edit_Idx_o, Edit_Buf_o, Err_o
  );
endinterface

// File: rtl/time_set_ctrl.sv
// time_set_ctrl: keypad-driven time/alarm setting controller.
// Runs a digit-entry edit session with per-digit range checks, loads the
// clock counter on commit, holds the alarm time/enable and exposes the edit
// state for the display. Edit sessions time out after TIMEOUT_S seconds
// without a key.
// Ports:
//   Clk    system clock
//   Rst_n  asynchronous active-low reset
//   bus    time_set_if.slave (key events in, time/alarm/edit state out)
//
// state      | meaning
// IDLE       | no session; SET / ALARM-SET open one, 14 toggles alarm enable
// EDIT_TIME  | editing a 6-digit time in the buffer
// EDIT_ALARM | editing a 4-digit alarm in the buffer
// COMMIT     | one cycle after OK; results were registered on the OK edge
module time_set_ctrl #(
  parameter int unsigned CLK_FREQ  = 27_000_000,
  parameter int unsigned TIMEOUT_S = 10
) (
  input logic       Clk,
  input logic       Rst_n,
  time_set_if.slave bus
);

  localparam int unsigned LIMIT = CLK_FREQ * TIMEOUT_S;
  localparam int CNT_W = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(LIMIT - 1);

  localparam logic [3:0] K_SET    = 4'd11;
  localparam logic [3:0] K_OK     = 4'd12;
  localparam logic [3:0] K_CANCEL = 4'd13;
  localparam logic [3:0] K_BACK   = 4'd14;
  localparam logic [3:0] K_ALARM  = 4'd15;

  typedef enum logic [1:0] {IDLE, EDIT_TIME, EDIT_ALARM, COMMIT} state_t;

  state_t           state;
  logic [CNT_W-1:0] tcnt;
  logic [23:0]      set_time;
  logic             set_load;
  logic [15:0]      alarm_time;
  logic             alarm_en;
  logic             edit_active;
  logic             edit_target;
  logic [2:0]       edit_idx;
  logic [23:0]      edit_buf;
  logic             err;

  logic [2:0]  last_idx;
  logic [3:0]  dmax;
  logic        digit_ok;
  logic [23:0] wr_buf;

  always_comb begin
    last_idx = edit_target ? 3'd3 : 3'd5;
    case (edit_idx)
      3'd0:       dmax = 4'd2;
      3'd1:       dmax = (edit_buf[23:20] == 4'd2) ? 4'd3 : 4'd9;
      3'd2, 3'd4: dmax = 4'd5;
      default:    dmax = 4'd9;
    endcase
    digit_ok = (bus.Key_Value <= dmax);
    wr_buf = edit_buf;
    for (int i = 0; i < 6; i++) begin
      if (edit_idx == 3'(i)) wr_buf[23-4*i -: 4] = bus.Key_Value;
    end
    // Ht = 2 with Ho > 3 would be an illegal hour; keep the buffer legal.
    if (edit_idx == 3'd0 && bus.Key_Value == 4'd2 && edit_buf[19:16] > 4'd3)
      wr_buf[19:16] = 4'd0;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state       <= IDLE;
      tcnt        <= '0;
      set_time    <= '0;
      set_load    <= 1'b0;
      alarm_time  <= 16'h0700;
      alarm_en    <= 1'b0;
      edit_active <= 1'b0;
      edit_target <= 1'b0;
      edit_idx    <= '0;
      edit_buf    <= '0;
      err         <= 1'b0;
    end else begin
      err      <= 1'b0;
      set_load <= 1'b0;
      case (state)
        IDLE: begin
          tcnt <= '0;
          if (bus.Key_flag) begin
            case (bus.Key_Value)
              K_SET: begin
                edit_buf    <= bus.Cur_Time_i;
                edit_idx    <= '0;
                edit_target <= 1'b0;
                edit_active <= 1'b1;
                state       <= EDIT_TIME;
              end
              K_ALARM: begin
                edit_buf    <= {alarm_time, 8'h00};
                edit_idx    <= '0;
                edit_target <= 1'b1;
                edit_active <= 1'b1;
                state       <= EDIT_ALARM;
              end
              K_BACK:  alarm_en <= ~alarm_en;
              default: ;
            endcase
          end
        end
        EDIT_TIME, EDIT_ALARM: begin
          if (bus.Key_flag) begin
            // A key in the timeout cycle wins: it is processed and the timer restarts.
            tcnt <= '0;
            if (bus.Key_Value <= 4'd9) begin
              if (digit_ok) begin
                edit_buf <= wr_buf;
                if (edit_idx != last_idx) edit_idx <= edit_idx + 3'd1;
              end else begin
                err <= 1'b1;
              end
            end else begin
              case (bus.Key_Value)
                K_SET, K_ALARM: err <= 1'b1;
                K_OK: begin
                  state <= COMMIT;
                  if (!edit_target) begin
                    set_time <= edit_buf;
                    set_load <= 1'b1;
                  end else begin
                    alarm_time <= edit_buf[23:8];
                    alarm_en   <= 1'b1;
                  end
                end
                K_CANCEL: begin
                  state       <= IDLE;
                  edit_active <= 1'b0;
                end
                K_BACK: if (edit_idx != 3'd0) edit_idx <= edit_idx - 3'd1;
                default: ;
              endcase
            end
          end else if (tcnt == CNT_TC) begin
            state       <= IDLE;
            edit_active <= 1'b0;
            tcnt        <= '0;
          end else begin
            tcnt <= tcnt + CNT_W'(1);
          end
        end
        COMMIT: begin
          state       <= IDLE;
          edit_active <= 1'b0;
          tcnt        <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.Set_Time_o    = set_time;
  assign bus.Set_Load_o    = set_load;
  assign bus.Alarm_Time_o  = alarm_time;
  assign bus.Alarm_En_o    = alarm_en;
  assign bus.Edit_Active_o = edit_active;
  assign bus.Edit_Target_o = edit_target;
  assign bus.Edit_Idx_o    = edit_idx;
  assign bus.Edit_Buf_o    = edit_buf;
  assign bus.Err_o         = err;

endmodule

// File: tb/tb_time_set_ctrl.sv
// tb_time_set_ctrl: scoreboard bench for time_set_ctrl. Stimulus pushes the
// expected response, a negedge monitor pops it when the DUT pulses Set_Load_o
// or Err_o, or when the stimulus raises the probe strobe for a snapshot.
module tb_time_set_ctrl;

  logic Clk = 1'b0;
  logic Rst_n = 1'b0;
  logic probe = 1'b0;

  always #5 Clk = ~Clk;

  time_set_if bus ();

  time_set_ctrl #(.CLK_FREQ(100), .TIMEOUT_S(1)) dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [23:0] set_time;
    logic        set_load;
    logic [15:0] alarm_time;
    logic        alarm_en;
    logic        edit_active;
    logic        edit_target;
    logic [2:0]  edit_idx;
    logic [23:0] edit_buf;
    logic        err;
  } snap_t;

  localparam int EV_LOAD = 0;
  localparam int EV_ERR  = 1;
  localparam int EV_SNAP = 2;

  typedef struct {
    int    kind;
    string name;
    snap_t val;
    snap_t mask;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  snap_t cur;

  task automatic push(input int kind, input string name, input snap_t v, input snap_t m);
    exp_t e;
    e.kind = kind; e.name = name; e.val = v; e.mask = m;
    sb.push_back(e);
  endtask

  task automatic exp_load(input string name, input logic [23:0] t);
    snap_t v = '0; snap_t m = '0;
    v.set_load = 1'b1; m.set_load = 1'b1;
    v.set_time = t;    m.set_time = '1;
    push(EV_LOAD, name, v, m);
  endtask

  task automatic exp_err(input string name, input logic [2:0] idx, input logic [23:0] b);
    snap_t v = '0; snap_t m = '0;
    v.err = 1'b1;    m.err = 1'b1;
    v.edit_idx = idx; m.edit_idx = '1;
    v.edit_buf = b;   m.edit_buf = '1;
    push(EV_ERR, name, v, m);
  endtask

  task automatic exp_edit(input string name, input logic tgt, input logic [2:0] idx,
                          input logic [23:0] b);
    snap_t v = '0; snap_t m = '0;
    v.edit_active = 1'b1; m.edit_active = 1'b1;
    v.edit_target = tgt;  m.edit_target = 1'b1;
    v.edit_idx = idx;     m.edit_idx = '1;
    v.edit_buf = b;       m.edit_buf = '1;
    m.err = 1'b1;
    push(EV_SNAP, name, v, m);
  endtask

  task automatic exp_alarm(input string name, input logic [15:0] a, input logic en);
    snap_t v = '0; snap_t m = '0;
    v.alarm_time = a; m.alarm_time = '1;
    v.alarm_en = en;  m.alarm_en = 1'b1;
    m.edit_active = 1'b1; m.set_load = 1'b1; m.err = 1'b1;
    push(EV_SNAP, name, v, m);
  endtask

  // Idle-state snapshot of every output (Edit_Active, Set_Load, Err all 0).
  task automatic exp_full(input string name, input logic [23:0] st, input logic [15:0] a,
                          input logic en, input logic tgt, input logic [2:0] idx,
                          input logic [23:0] b);
    snap_t v = '0; snap_t m = '1;
    v.set_time = st; v.alarm_time = a; v.alarm_en = en;
    v.edit_target = tgt; v.edit_idx = idx; v.edit_buf = b;
    push(EV_SNAP, name, v, m);
  endtask

  task automatic key(input logic [3:0] k);
    bus.Key_flag = 1'b1;
    bus.Key_Value = k;
    @(posedge Clk);
    #1;
    bus.Key_flag = 1'b0;
  endtask

  task automatic do_probe();
    probe = 1'b1;
    @(posedge Clk);
    #1;
    probe = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic handle(input int kind, input snap_t s);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event kind=%0d got=%h (nothing expected)", kind, s);
    end else begin
      e = sb.pop_front();
      if (e.kind != kind) begin
        errors++;
        $display("FAIL %s event kind got=%0d want=%0d", e.name, kind, e.kind);
      end else if (((s ^ e.val) & e.mask) != '0) begin
        errors++;
        $display("FAIL %s got=%h want=%h mask=%h", e.name, s & e.mask, e.val & e.mask, e.mask);
      end
    end
  endtask

  always @(negedge Clk) begin
    cur = '{bus.Set_Time_o, bus.Set_Load_o, bus.Alarm_Time_o, bus.Alarm_En_o,
            bus.Edit_Active_o, bus.Edit_Target_o, bus.Edit_Idx_o, bus.Edit_Buf_o, bus.Err_o};
    if (bus.Set_Load_o) handle(EV_LOAD, cur);
    if (bus.Err_o)      handle(EV_ERR, cur);
    if (probe)          handle(EV_SNAP, cur);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.Key_flag = 1'b0;
    bus.Key_Value = 4'd0;
    bus.Cur_Time_i = 24'h000000;
    idle_cycles(3);
    Rst_n = 1'b1;
    exp_full("reset", 24'h0, 16'h0700, 1'b0, 1'b0, 3'd0, 24'h0);
    do_probe();

    // Full time edit and commit
    bus.Cur_Time_i = 24'h123456;
    key(4'd11);
    exp_edit("set_opens", 1'b0, 3'd0, 24'h123456);
    do_probe();
    key(4'd2); key(4'd3); key(4'd5); key(4'd9); key(4'd0); key(4'd0);
    exp_edit("six_digits", 1'b0, 3'd5, 24'h235900);
    do_probe();
    exp_load("commit_load", 24'h235900);
    exp_edit("commit_active", 1'b0, 3'd5, 24'h235900);
    key(4'd12);
    do_probe();
    exp_full("after_commit", 24'h235900, 16'h0700, 1'b0, 1'b0, 3'd5, 24'h235900);
    do_probe();

    // Hour forcing and range rejection; Cur_Time_i changes are ignored mid-edit
    bus.Cur_Time_i = 24'h193000;
    key(4'd11);
    bus.Cur_Time_i = 24'h111111;
    exp_edit("buf_193000", 1'b0, 3'd0, 24'h193000);
    do_probe();
    key(4'd2);
    exp_edit("ht2_forces_ho0", 1'b0, 3'd1, 24'h203000);
    do_probe();
    exp_err("ho4_rejected", 3'd1, 24'h203000);
    key(4'd4);
    key(4'd3);
    exp_edit("ho3_ok", 1'b0, 3'd2, 24'h233000);
    do_probe();
    key(4'd10);
    exp_edit("key10_ignored", 1'b0, 3'd2, 24'h233000);
    do_probe();
    exp_err("set_in_edit", 3'd2, 24'h233000);
    key(4'd11);
    exp_err("alarmset_in_edit", 3'd2, 24'h233000);
    key(4'd15);
    key(4'd13);
    exp_full("cancel", 24'h235900, 16'h0700, 1'b0, 1'b0, 3'd2, 24'h233000);
    do_probe();

    // Index saturation at both ends
    key(4'd11);
    exp_err("ht7_rejected", 3'd0, 24'h111111);
    key(4'd7);
    key(4'd14);
    exp_edit("back_at_0", 1'b0, 3'd0, 24'h111111);
    do_probe();
    key(4'd1); key(4'd9); key(4'd5); key(4'd9); key(4'd5); key(4'd8);
    exp_edit("idx5_reached", 1'b0, 3'd5, 24'h195958);
    do_probe();
    key(4'd9);
    exp_edit("idx5_overwrite", 1'b0, 3'd5, 24'h195959);
    do_probe();
    key(4'd14);
    exp_edit("back_to_4", 1'b0, 3'd4, 24'h195959);
    do_probe();
    exp_err("tens6_rejected", 3'd4, 24'h195959);
    key(4'd6);
    key(4'd13);

    // Alarm edit
    key(4'd15);
    exp_edit("alarm_opens", 1'b1, 3'd0, 24'h070000);
    do_probe();
    key(4'd0); key(4'd6); key(4'd4); key(4'd5); key(4'd5);
    exp_edit("alarm_idx3_sat", 1'b1, 3'd3, 24'h064500);
    do_probe();
    key(4'd12);
    idle_cycles(1);
    exp_full("alarm_commit", 24'h235900, 16'h0645, 1'b1, 1'b1, 3'd3, 24'h064500);
    do_probe();
    key(4'd14);
    exp_alarm("alarm_toggle_off", 16'h0645, 1'b0);
    do_probe();
    key(4'd14); key(4'd10); key(4'd12);
    exp_alarm("alarm_toggle_on", 16'h0645, 1'b1);
    do_probe();

    // Timeout: 100 idle cycles close the session
    bus.Cur_Time_i = 24'h123456;
    key(4'd11);
    idle_cycles(98);
    exp_edit("timeout_98", 1'b0, 3'd0, 24'h123456);
    do_probe();
    exp_edit("timeout_99", 1'b0, 3'd0, 24'h123456);
    do_probe();
    exp_full("timeout_100", 24'h235900, 16'h0645, 1'b1, 1'b0, 3'd0, 24'h123456);
    do_probe();

    // Key at cycle 99 restarts the timer
    key(4'd11);
    idle_cycles(98);
    key(4'd1);
    idle_cycles(99);
    exp_edit("restart_99", 1'b0, 3'd1, 24'h123456);
    do_probe();
    exp_full("restart_100", 24'h235900, 16'h0645, 1'b1, 1'b0, 3'd1, 24'h123456);
    do_probe();

    // SET,1,CANCEL changes only the buffer
    bus.Cur_Time_i = 24'h085500;
    key(4'd11); key(4'd1); key(4'd13);
    exp_full("cancel_buf_only", 24'h235900, 16'h0645, 1'b1, 1'b0, 3'd1, 24'h185500);
    do_probe();

    // Reset mid-session
    bus.Cur_Time_i = 24'h200000;
    key(4'd11); key(4'd1);
    exp_edit("pre_reset", 1'b0, 3'd1, 24'h100000);
    do_probe();
    Rst_n = 1'b0;
    exp_full("mid_reset", 24'h0, 16'h0700, 1'b0, 1'b0, 3'd0, 24'h0);
    do_probe();
    Rst_n = 1'b1;
    idle_cycles(2);
    exp_full("post_reset", 24'h0, 16'h0700, 1'b0, 1'b0, 3'd0, 24'h0);
    do_probe();

    idle_cycles(3);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL missing_events got=%0d pending want=0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/time_set_ctrl.md
Name: time_set_ctrl

Overview:
- Keypad-driven time/alarm setting controller for the clock design.
- Consumes the one-cycle key events from the 4x4 keypad scanner and runs a digit-entry edit session with per-digit range validation.
- Configures the clock time counter through a load pulse and holds the alarm time and alarm-enable registers.
- Drives edit-state outputs to the display block, which uses them to show the edit buffer and blink the digit being edited.

Parameters:
- CLK_FREQ, 27_000_000, Clk frequency in Hz.
- TIMEOUT_S, 10, seconds of key inactivity after which an edit session is abandoned.

Ports:
- Clk  input  1  system clock.
- Rst_n  input  1  asynchronous active-low reset.
- Key_flag  input  1  one-cycle key-event strobe from the keypad scanner.
- Key_Value  input  4  key code, valid in the cycle Key_flag is high.
- Cur_Time_i  input  24  running time from the clock counter, BCD {Ht,Ho,Mt,Mo,St,So}.
- Set_Time_o  output  24  time to load into the clock counter, BCD.
- Set_Load_o  output  1  one-cycle pulse; clock counter loads Set_Time_o.
- Alarm_Time_o  output  16  alarm time, BCD {Ht,Ho,Mt,Mo}.
- Alarm_En_o  output  1  alarm enabled.
- Edit_Active_o  output  1  high while an edit session is open.
- Edit_Target_o  output  1  0 = editing time, 1 = editing alarm.
- Edit_Idx_o  output  3  index of the digit being edited, 0 = hour tens.
- Edit_Buf_o  output  24  edit buffer for display; alarm edits use the upper 16 bits, lower 8 bits = 0.
- Err_o  output  1  one-cycle pulse when a key is rejected.

Behaviour:
- Reset (asynchronous, active-low Rst_n; clock Clk). All outputs 0 except Alarm_Time_o = 16'h0700. State = IDLE, timeout counter = 0.
- Key codes:
  - 0..9 = digits.
  - 11 = SET, 12 = OK, 13 = CANCEL, 14 = BACK/ALARM-TOGGLE, 15 = ALARM-SET.
  - 10 never arrives from the scanner; if received, it is ignored without Err_o.
- All actions happen on the Clk edge where Key_flag = 1. Keys are ignored when Key_flag = 0.
- States: IDLE, EDIT_TIME, EDIT_ALARM, COMMIT.
- IDLE:
  - SET: Edit_Buf_o <= Cur_Time_i sampled in that cycle; Idx <= 0; go to EDIT_TIME.
  - ALARM-SET: Edit_Buf_o <= {Alarm_Time_o, 8'h00}; Idx <= 0; go to EDIT_ALARM.
  - 14: toggle Alarm_En_o.
  - Any other key: ignored, no Err_o.
- EDIT_* states, digit key d at Idx:
  - Limits:
    - Idx0 (Ht): d <= 2.
    - Idx1 (Ho): d <= 9 if Ht < 2, else d <= 3.
    - Idx2 and Idx4 (tens): d <= 5.
    - Idx3 and Idx5 (ones): d <= 9.
  - Valid digit: write d into the buffer nibble at Idx; Idx <= Idx + 1, saturating at LAST (5 for time, 3 for alarm). At LAST the digit is overwritten in place.
  - Writing Ht = 2 while Ho > 3 also forces Ho to 0, so the buffer is always a legal time.
  - Invalid digit: buffer and Idx unchanged; Err_o pulses in the next cycle.
- EDIT_* states, command keys:
  - BACK: Idx <= Idx - 1, saturating at 0; buffer unchanged.
  - OK: go to COMMIT.
  - CANCEL: go to IDLE; no outputs are changed.
  - SET or ALARM-SET: Err_o pulse; state unchanged.
- COMMIT lasts exactly one cycle, then IDLE.
  - Time target: Set_Time_o <= buffer and Set_Load_o = 1 for that cycle.
  - Alarm target: Alarm_Time_o <= buffer[23:8] and Alarm_En_o <= 1.
  - Latency: OK key at edge N → Set_Load_o high in cycle N+1 only. Set_Time_o holds its value until the next commit.
- Timeout:
  - A counter of width ceil(log2(CLK_FREQ*TIMEOUT_S)) runs only in EDIT_* states and clears on every Key_flag.
  - Reaching CLK_FREQ*TIMEOUT_S−1 with no key forces IDLE, same as CANCEL.
  - A key arriving in the same cycle as the timeout wins: the key is processed and the counter clears.
- Edit_Active_o = 1 in EDIT_* and COMMIT. Edit_Target_o and Edit_Idx_o are valid while Edit_Active_o = 1 and hold their last values otherwise.
- Edit_Buf_o follows the buffer in every state. It is not cleared on return to IDLE.
- Cur_Time_i changes during an edit do not affect the buffer.
- Rst_n assertion mid-session aborts immediately to the reset values; no Set_Load_o is produced.

Test Plan:
- Reset, then Cur_Time_i = 24'h123456; keys SET,2,3,5,9,0,0,OK → Set_Load_o high exactly one cycle after the OK strobe with Set_Time_o = 24'h235900; Edit_Active_o falls one cycle later.
- Buffer 24'h193000 after SET; key 2 at Idx0 → buffer 24'h203000, Idx = 1; key 4 → rejected, Err_o pulse, buffer unchanged; key 3 → buffer 24'h233000.
- SET then key 7 at Idx0 → Err_o, Idx stays 0; BACK at Idx0 → Idx 0; six valid digits then a seventh digit 9 → overwrites Idx5, Idx stays 5.
- ALARM-SET,0,6,4,5,OK → Alarm_Time_o = 16'h0645, Alarm_En_o = 1, Set_Load_o never asserted; key 14 in IDLE → Alarm_En_o = 0.
- CLK_FREQ = 100, TIMEOUT_S = 1; SET, then no key for 100 cycles → IDLE, no Set_Load_o. Repeat with a digit key at cycle 99 → session stays open and the timeout restarts.
- SET,1,CANCEL → no output changes except Edit_Buf_o. SET,1, then Rst_n low mid-session → all outputs at reset values, Alarm_Time_o = 16'h0700.
